// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for the serial packed-BCD adder.
// No latency of its own: plain wires between requester and adder.
// Flow control is start/busy/done; the requester waits for done before the next start.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  // request side
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  cin;
  // status / result side
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  // requester drives operands and start, observes status and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, err
  );

  // adder consumes operands and start, drives status and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one decimal digit per clock through one digit-add-and-correct stage.
// Latency: DIGITS+2 cycles start edge to done (2 cycles when an operand has a non-BCD digit).
// No queueing: start is ignored while busy or during the done cycle; results hold until the next done.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input logic              clk,
  input logic              rst_n,
  bcd_serial_adder_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  // index needs at least one bit even when there is a single digit
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          c_q;       // decimal carry between digits, seeded with cin
  logic [IW-1:0] idx;
  logic [W-1:0]  res_q;     // digits accumulated during RUN
  logic          err_pend;  // operand check failed, FIN reports error

  logic          busy_q;
  logic          done_q;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          err_q;

  logic          ops_ok;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [4:0]    dig_t;
  logic [3:0]    dig_s;
  logic          dig_c;

  // every nibble of both incoming operands must be a legal BCD digit (0..9)
  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
        ops_ok = 1'b0;
      end
    end
  end

  // pick the current digit of each captured operand
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  // binary digit sum (0..19), then +6 correction when it leaves the decimal range
  always_comb begin
    dig_t = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, c_q};
    if (dig_t > 5'd9) begin
      dig_s = dig_t[3:0] + 4'd6;
      dig_c = 1'b1;
    end else begin
      dig_s = dig_t[3:0];
      dig_c = 1'b0;
    end
  end

  // sequencer: capture in IDLE, one digit per edge in RUN, publish results in FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      idx      <= '0;
      res_q    <= '0;
      err_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // the done cycle is already IDLE; a start there is dropped, not queued
          if (bus.start && !done_q) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            c_q      <= bus.cin;
            idx      <= '0;
            busy_q   <= 1'b1;
            err_pend <= !ops_ok;
            state    <= ops_ok ? S_RUN : S_FIN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
              res_q[4*i +: 4] <= dig_s;
            end
          end
          c_q <= dig_c;
          if (idx == LAST_IDX) begin
            state <= S_FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_FIN: begin
          if (err_pend) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            sum_q  <= res_q;
            cout_q <= c_q;
            err_q  <= 1'b0;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (DIGITS=4 main instance, DIGITS=1 corner instance).
// Expected sums are hand-computed decimal additions; latency counted from the start edge.
// Outputs are sampled on the falling edge, inputs driven there too.
module tb_bcd_serial_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(4)) bus ();
  bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one addition on the 4-digit instance; lat = cycles from start edge to done cycle (-1 on timeout)
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                         output int lat, output int nbusy);
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.cin = ci; bus.start = 1'b1;
    @(posedge clk);
    lat = -1;
    nbusy = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // scramble inputs right after capture; the operation must not notice
        bus.start = 1'b0; bus.a = 16'hFFFF; bus.b = 16'h9999; bus.cin = 1'b1;
      end
      if (bus.done) begin
        lat = k + 1;
        break;
      end
      if (bus.busy) nbusy++;
    end
  endtask

  initial begin
    int lat, nbusy, ndone, drop, first_k, gap;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum",  bus.sum,  0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_err",  bus.err,  0);
    rst_n = 1'b1;

    // basic add with latency and busy width
    run_add(16'h1234, 16'h5678, 1'b0, lat, nbusy);
    chk("t1_lat",  lat, 6);
    chk("t1_busy", nbusy, 5);
    chk("t1_sum",  bus.sum, 16'h6912);
    chk("t1_cout", bus.cout, 0);
    chk("t1_err",  bus.err, 0);

    // carry ripples through all corrected digits
    run_add(16'h9999, 16'h0001, 1'b0, lat, nbusy);
    chk("t2_sum",  bus.sum, 16'h0000);
    chk("t2_cout", bus.cout, 1);

    // maximum result
    run_add(16'h9999, 16'h9999, 1'b1, lat, nbusy);
    chk("t3_sum",  bus.sum, 16'h9999);
    chk("t3_cout", bus.cout, 1);

    // non-BCD digit in a
    run_add(16'h12A4, 16'h0001, 1'b0, lat, nbusy);
    chk("t4_lat",  lat, 2);
    chk("t4_busy", nbusy, 1);
    chk("t4_err",  bus.err, 1);
    chk("t4_sum",  bus.sum, 0);
    chk("t4_cout", bus.cout, 0);
    run_add(16'h0005, 16'h0005, 1'b0, lat, nbusy);
    chk("t4b_sum", bus.sum, 16'h0010);
    chk("t4b_err", bus.err, 0);

    // carry-in only
    run_add(16'h0000, 16'h0000, 1'b1, lat, nbusy);
    chk("t5_sum",  bus.sum, 16'h0001);
    chk("t5_cout", bus.cout, 0);

    // start held high throughout one add, dropped right after the done cycle
    @(negedge clk);
    bus.a = 16'h0500; bus.b = 16'h0500; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    ndone = 0;
    drop = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        drop = 1;
      end else if (drop == 1) begin
        chk("t6_busy_after_done", bus.busy, 0);
        bus.start = 1'b0;
        drop = 2;
      end
    end
    bus.start = 1'b0;
    chk("t6_ndone", ndone, 1);
    chk("t6_sum",   bus.sum, 16'h1000);

    // back-to-back: held start re-triggers in the IDLE cycle after done
    @(negedge clk);
    bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    ndone = 0;
    first_k = -1;
    gap = -1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first_k < 0) first_k = k;
        else gap = k - first_k;
      end
    end
    bus.start = 1'b0;
    chk("t7_ndone", ndone, 2);
    chk("t7_gap",   gap, 7);
    chk("t7_sum",   bus.sum, 16'h0002);
    repeat (3) @(negedge clk);

    // asynchronous reset in RUN at digit index 2
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_busy", bus.busy, 0);
    chk("t8_sum",  bus.sum, 0);
    chk("t8_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("t8_no_done", ndone, 0);
    run_add(16'h0001, 16'h0002, 1'b0, lat, nbusy);
    chk("t8_lat", lat, 6);
    chk("t8_sum", bus.sum, 16'h0003);

    // single-digit instance
    @(negedge clk);
    bus1.a = 4'h9; bus1.b = 4'h9; bus1.cin = 1'b1; bus1.start = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (bus1.done) begin
        lat = k + 1;
        break;
      end
    end
    chk("d1_lat",  lat, 3);
    chk("d1_sum",  bus1.sum, 4'h9);
    chk("d1_cout", bus1.cout, 1);
    chk("d1_err",  bus1.err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
